// File: rtl/kuz_pkg.sv
// Shared constants and types for the Kuznechik linear-transform datapath.
// Optional inverse mode in kuz_lin_seq is enabled with KUZ_LIN_INVERSE_EN.
package kuz_pkg;

  localparam int         BLK_W    = 128;
  localparam logic [7:0] KUZ_POLY = 8'hC3;

  // l-function coefficients, indexed by byte position (byte 0 = bits [7:0])
  localparam logic [7:0] KUZ_LCOEF [0:15] = '{
    8'd1,   8'd148, 8'd32,  8'd133, 8'd16,  8'd194, 8'd192, 8'd1,
    8'd251, 8'd1,   8'd192, 8'd194, 8'd16,  8'd133, 8'd32,  8'd148
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } kuz_state_e;

endpackage

// File: rtl/kuz_lin_lane_mux.sv
// Coefficient and operand-byte select for one multiplier lane at a given MAC cycle.
module kuz_lin_lane_mux
  import kuz_pkg::*;
#(
  parameter int LANES = 1,
  parameter int LANE  = 0,
  parameter int MCW   = 1
) (
  input  logic [MCW-1:0]   i_mac_cnt,
  input  logic [BLK_W-1:0] i_blk,
  output logic [7:0]       o_coef,
  output logic [7:0]       o_byte
);

  logic [3:0] w_idx;

  // Lane LANE of cycle j handles byte j*LANES+LANE
  assign w_idx  = 4'((32'(i_mac_cnt) * LANES) + LANE);
  assign o_coef = KUZ_LCOEF[w_idx];
  assign o_byte = i_blk[{w_idx, 3'b000} +: 8];

endmodule

// File: rtl/multGF.sv
// Combinational GF(2^8) multiplier, reduction polynomial x^8+x^7+x^6+x+1.
module multGF
  import kuz_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_p
);

  logic [7:0] w_acc;
  logic [7:0] w_sh;

  // Shift-and-add: w_sh walks through a*x^k, reduced on every overflow
  always_comb begin
    w_acc = '0;
    w_sh  = i_a;
    for (int k = 0; k < 8; k++) begin
      if (i_b[k]) w_acc = w_acc ^ w_sh;
      w_sh = w_sh[7] ? ((w_sh << 1) ^ KUZ_POLY) : (w_sh << 1);
    end
    o_p = w_acc;
  end

endmodule

// File: rtl/kuz_lin_seq.sv
// Kuznechik linear transform L = R^ROUNDS, time-sharing LANES GF multipliers.
// Define KUZ_LIN_INVERSE_EN to add the in_inv port and the inverse transform.
module kuz_lin_seq
  import kuz_pkg::*;
#(
  parameter int LANES  = 1,
  parameter int ROUNDS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
`ifdef KUZ_LIN_INVERSE_EN
  input  logic             in_inv,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             busy
);

  localparam int K   = 16 / LANES;
  localparam int MCW = (K > 1) ? $clog2(K) : 1;
  localparam int RCW = $clog2(ROUNDS + 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("kuz_lin_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  kuz_state_e       r_state;
  kuz_state_e       w_state_nxt;
  logic [BLK_W-1:0] r_s;
  logic [7:0]       r_acc;
  logic [MCW-1:0]   r_mac_cnt;
  logic [RCW-1:0]   r_round_cnt;
  logic [BLK_W-1:0] w_b;
  logic [BLK_W-1:0] w_s_step;
  logic [7:0]       w_prod_x;
  logic [7:0]       w_l;
  logic             w_last_mac;
  logic             w_last_round;
  logic [7:0]       w_coef [LANES];
  logic [7:0]       w_byte [LANES];
  logic [7:0]       w_prod [LANES];

`ifdef KUZ_LIN_INVERSE_EN
  logic r_inv;

  // Inverse step works on the block rotated left by one byte
  assign w_b      = r_inv ? {r_s[119:0], r_s[127:120]} : r_s;
  assign w_s_step = r_inv ? {w_b[127:8], w_l} : {w_l, r_s[127:8]};
`else
  assign w_b      = r_s;
  assign w_s_step = {w_l, r_s[127:8]};
`endif

  for (genvar m = 0; m < LANES; m++) begin : g_lane
    kuz_lin_lane_mux #(
      .LANES (LANES),
      .LANE  (m),
      .MCW   (MCW)
    ) u_mux (
      .i_mac_cnt (r_mac_cnt),
      .i_blk     (w_b),
      .o_coef    (w_coef[m]),
      .o_byte    (w_byte[m])
    );

    multGF u_mul (
      .i_a (w_coef[m]),
      .i_b (w_byte[m]),
      .o_p (w_prod[m])
    );
  end

  always_comb begin
    w_prod_x = '0;
    for (int m = 0; m < LANES; m++) w_prod_x = w_prod_x ^ w_prod[m];
  end

  assign w_l          = r_acc ^ w_prod_x;
  assign w_last_mac   = (r_mac_cnt == MCW'(K - 1));
  assign w_last_round = (r_round_cnt == RCW'(ROUNDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = MAC;
      MAC:     if (w_last_mac && w_last_round) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      IDLE: in_ready = 1'b1;
      MAC:  busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  assign out_data = r_s;

  // The last MAC cycle of a step folds its own products into l directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s         <= '0;
      r_acc       <= '0;
      r_mac_cnt   <= '0;
      r_round_cnt <= '0;
`ifdef KUZ_LIN_INVERSE_EN
      r_inv       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_s         <= in_data;
            r_acc       <= '0;
            r_mac_cnt   <= '0;
            r_round_cnt <= '0;
`ifdef KUZ_LIN_INVERSE_EN
            r_inv       <= in_inv;
`endif
          end
        end
        MAC: begin
          if (w_last_mac) begin
            r_s         <= w_s_step;
            r_acc       <= '0;
            r_mac_cnt   <= '0;
            r_round_cnt <= r_round_cnt + RCW'(1);
          end else begin
            r_acc     <= w_l;
            r_mac_cnt <= r_mac_cnt + MCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kuz_lin_seq.sv
// Scoreboard bench for kuz_lin_seq: dut0 is the default build (LANES=1, ROUNDS=16),
// dut1 is a single-R, all-lane build (LANES=16, ROUNDS=1).
module tb_kuz_lin_seq;

  typedef struct {
    int           dut;
    logic [127:0] data;
    int           accCycle;
  } expT;

  localparam int LAT0 = 256;
  localparam int LAT1 = 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         inValid  [2];
  logic         inReady  [2];
  logic         outValid [2];
  logic         outReady [2];
  logic         busy     [2];
  logic [127:0] inData   [2];
  logic [127:0] outData  [2];
`ifdef KUZ_LIN_INVERSE_EN
  logic         inInv    [2];
  logic         stimInv = 1'b0;
`endif

  int           cmpCnt   = 0;
  int           failCnt  = 0;
  int           cycleCnt = 0;
  expT          expQ[$];
  expT          monE;
  logic         presented [2] = '{1'b0, 1'b0};
  logic         haveExp   [2] = '{1'b0, 1'b0};
  logic [127:0] curExp    [2];

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  kuz_lin_seq #(.LANES(1), .ROUNDS(16)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid[0]),
    .in_ready  (inReady[0]),
    .in_data   (inData[0]),
`ifdef KUZ_LIN_INVERSE_EN
    .in_inv    (inInv[0]),
`endif
    .out_valid (outValid[0]),
    .out_ready (outReady[0]),
    .out_data  (outData[0]),
    .busy      (busy[0])
  );

  kuz_lin_seq #(.LANES(16), .ROUNDS(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid[1]),
    .in_ready  (inReady[1]),
    .in_data   (inData[1]),
`ifdef KUZ_LIN_INVERSE_EN
    .in_inv    (inInv[1]),
`endif
    .out_valid (outValid[1]),
    .out_ready (outReady[1]),
    .out_data  (outData[1]),
    .busy      (busy[1])
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] expd);
    cmpCnt++;
    if (act !== expd) begin
      failCnt++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expd);
    end
  endtask

  // Offer one block to DUT d and queue its expected result once accepted
  task automatic applyStimulus(input int d, input logic [127:0] data, input logic [127:0] expd);
    int  n = 0;
    expT e;
    @(negedge clk);
    inValid[d] = 1'b1;
    inData[d]  = data;
`ifdef KUZ_LIN_INVERSE_EN
    inInv[d]   = stimInv;
`endif
    while (!inReady[d] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!inReady[d]) begin
      cmpCnt++;
      failCnt++;
      $display("[TB] FAIL accept_timeout dut%0d: got in_ready=0 expected 1 within 1000 cycles", d);
      inValid[d] = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      e.dut      = d;
      e.data     = expd;
      e.accCycle = cycleCnt;
      expQ.push_back(e);
      inValid[d] = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((expQ.size() != 0 || presented[0] || presented[1]) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (n >= 2000) begin
      cmpCnt++;
      failCnt++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  // Monitor: on the first cycle an output is presented, pop and check data and latency
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n || !outValid[d]) begin
        presented[d] = 1'b0;
      end else begin
        if (!presented[d]) begin
          if (expQ.size() == 0 || expQ[0].dut != d) begin
            cmpCnt++;
            failCnt++;
            $display("[TB] FAIL unexpected_output dut%0d: got %h expected no output", d, outData[d]);
            haveExp[d] = 1'b0;
          end else begin
            monE       = expQ.pop_front();
            curExp[d]  = monE.data;
            haveExp[d] = 1'b1;
            checkOutput($sformatf("latency_dut%0d", d), 128'(cycleCnt - monE.accCycle),
                        128'((d == 0) ? LAT0 : LAT1));
          end
          presented[d] = 1'b1;
        end
        if (haveExp[d]) checkOutput($sformatf("out_data_dut%0d", d), outData[d], curExp[d]);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 50000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      inValid[d]  = 1'b0;
      outReady[d] = 1'b1;
      inData[d]   = '0;
`ifdef KUZ_LIN_INVERSE_EN
      inInv[d]    = 1'b0;
`endif
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("rst_in_ready_dut%0d", d), 128'(inReady[d]), 128'(1));
      checkOutput($sformatf("rst_out_valid_dut%0d", d), 128'(outValid[d]), 128'(0));
      checkOutput($sformatf("rst_busy_dut%0d", d), 128'(busy[d]), 128'(0));
      checkOutput($sformatf("rst_out_data_dut%0d", d), outData[d], 128'h0);
    end
    rst_n = 1'b1;

    $display("[TB] full L vectors on dut0");
    applyStimulus(0, 128'h64a59400000000000000000000000000, 128'hd456584dd0e3e84cc3166e4b7fa2890d);
    @(negedge clk);
    checkOutput("mac_busy", 128'(busy[0]), 128'(1));
    checkOutput("mac_in_ready", 128'(inReady[0]), 128'(0));
    waitDrain();
    applyStimulus(0, 128'hd456584dd0e3e84cc3166e4b7fa2890d, 128'h79d26221b87b584cd42fbc4ffea5de9a);
    waitDrain();
    applyStimulus(0, 128'h0, 128'h0);
    waitDrain();

    $display("[TB] backpressure on dut0");
    outReady[0] = 1'b0;
    applyStimulus(0, 128'hd456584dd0e3e84cc3166e4b7fa2890d, 128'h79d26221b87b584cd42fbc4ffea5de9a);
    n = 0;
    while (!outValid[0] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_out_valid_rise", 128'(outValid[0]), 128'(1));
    inValid[0] = 1'b1;
    inData[0]  = 128'h64a59400000000000000000000000000;
    repeat (20) begin
      @(negedge clk);
      checkOutput("bp_in_ready", 128'(inReady[0]), 128'(0));
      checkOutput("bp_out_valid_hold", 128'(outValid[0]), 128'(1));
    end
    outReady[0] = 1'b1;
    applyStimulus(0, 128'h64a59400000000000000000000000000, 128'hd456584dd0e3e84cc3166e4b7fa2890d);
    waitDrain();

    $display("[TB] reset mid-MAC on dut0");
    applyStimulus(0, 128'h64a59400000000000000000000000000, 128'hd456584dd0e3e84cc3166e4b7fa2890d);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", 128'(outValid[0]), 128'(0));
    checkOutput("abort_in_ready", 128'(inReady[0]), 128'(1));
    checkOutput("abort_busy", 128'(busy[0]), 128'(0));
    void'(expQ.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 128'hd456584dd0e3e84cc3166e4b7fa2890d, 128'h79d26221b87b584cd42fbc4ffea5de9a);
    waitDrain();

    $display("[TB] single R vectors on dut1");
    applyStimulus(1, 128'h00000000000000000000000000000100, 128'h94000000000000000000000000000001);
    waitDrain();
    applyStimulus(1, 128'h00000000000000000000000000000001, 128'h01000000000000000000000000000000);
    waitDrain();
    applyStimulus(1, 128'h01000000000000000000000000000000, 128'h94010000000000000000000000000000);
    waitDrain();
    applyStimulus(1, 128'h01000000000000000000000000000100, 128'h00010000000000000000000000000001);
    waitDrain();
    applyStimulus(1, 128'h00000000000000000000000000020000, 128'h40000000000000000000000000000200);
    waitDrain();
    applyStimulus(1, 128'h00000000000000000000800000000000, 128'h6e000000000000000000008000000000);
    waitDrain();

`ifdef KUZ_LIN_INVERSE_EN
    $display("[TB] inverse L on dut0");
    stimInv = 1'b1;
    applyStimulus(0, 128'hd456584dd0e3e84cc3166e4b7fa2890d, 128'h64a59400000000000000000000000000);
    waitDrain();
    stimInv = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, failCnt);
    $finish;
  end

endmodule
